seven_seg_arb: RTL
==================

SEVEN_SEG_ARB -- requirements
Module: seven_seg_arb

Interface
REQ-001 Parameter pClkFreq, default 25000000, system clock frequency in Hz.
REQ-002 Parameter pHoldCnt, default pClkFreq/4, minimum ownership time in clk cycles (250 ms); legal range 1..2^24.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 req  input  4  per-requester display request, level, held until ack.
REQ-006 val0..val3  input  32 each  per-requester eight-digit hex value.
REQ-007 dp0..dp3  input  8 each  per-requester decimal-point mask.
REQ-008 ack  output  4  one-cycle pulse, value of that requester latched.
REQ-009 val_o  output  32  value to seven-segment driver.
REQ-010 dp_o  output  8  decimal-point mask to driver.
REQ-011 owner  output  2  index of requester currently shown.
REQ-012 busy  output  1  high while in HOLD.

Function
REQ-013 FSM states IDLE and HOLD only.
REQ-014 IDLE, req==0: stay IDLE; val_o/dp_o/owner retain last values.
REQ-015 IDLE, req!=0: winner = first asserted index scanning ptr, ptr+1, ... mod 4.
REQ-016 On that edge: val_o/dp_o <= winner's inputs, owner <= winner, ack[winner] <= 1, cnt <= pHoldCnt-1, ptr <= winner+1 mod 4, state <= HOLD.
REQ-017 ack is registered: asserted the cycle after the latching edge, exactly one cycle, at most one bit set.
REQ-018 HOLD, cnt!=0: cnt decrements by 1 each cycle; non-owner requests ignored (remain pending).
REQ-019 HOLD, cnt!=0, req[owner]==1 and ack[owner]==0: relatch owner's val/dp, pulse ack[owner], reload cnt <= pHoldCnt-1.
REQ-020 Requester whose ack is high in a cycle is not considered in that cycle (no double latch of the same request).
REQ-021 HOLD, cnt==0: state <= IDLE unconditionally; owner request that cycle is not serviced there, arbitrated in IDLE like any other.
REQ-022 pHoldCnt==1: HOLD lasts exactly one cycle.
REQ-023 Request-to-ack latency from IDLE: 1 cycle; worst case for a waiting requester: 4 ownership periods plus 4 cycles.
REQ-024 cnt is 24 bits, unsigned, never wraps (decrement suppressed at 0).
REQ-025 busy = (state==HOLD), registered.
REQ-026 Dropping req before ack: request withdrawn, no ack issued, no error.

Reset
REQ-027 rst asserted at any time: state IDLE, val_o 0, dp_o 0, owner 0, ack 0, busy 0, ptr 0, cnt 0, immediately (asynchronous).
REQ-028 Reset mid-HOLD or during an ack pulse: pulse truncated, no ack after release until a fresh arbitration.
REQ-029 First arbitration possible on the first clk edge after rst deasserts.

Structure
REQ-030 Shared package seven_seg_pkg holds: state type (IDLE, HOLD), NREQ=4, OWNER_W=2, CNT_W=24.
REQ-031 One sub-module rr_pick4: combinational round-robin picker (req[3:0], ptr[1:0] -> valid, idx[1:0]).
REQ-032 val_o/dp_o connect directly to the existing eight-digit seven-segment driver val/dp inputs; no segment decoding in this block.

Verification (pHoldCnt=8 unless noted)
REQ-033 Reset: rst pulse mid-HOLD -> all outputs 0 same cycle, state IDLE, no ack after release.
REQ-034 Single request: req=0001, val0=32'h12345678, dp0=8'h01 -> ack=0001 one cycle later, val_o=32'h12345678, owner=0, busy 8 cycles then IDLE.
REQ-035 Round robin: req=1111 held, each requester re-asserting after ack -> grant order 0,1,2,3,0, owners change every 9 cycles.
REQ-036 Owner refresh: owner 2 re-requests with val2=32'hDEADBEEF at cnt=3 -> ack[2], val_o updated, cnt reloaded to 7; req[1] waits.
REQ-037 Final-cycle collision: req[owner] and req[3] both asserted at cnt==0 -> no ack that cycle; IDLE arbitration from ptr picks next index.
REQ-038 pHoldCnt=1: req=0011 held -> acks alternate 0,1 every 2 cycles, never both set.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and sizes for the seven-segment display arbiter.
package seven_seg_pkg;
    localparam int NREQ    = 4;
    localparam int OWNER_W = 2;
    localparam int CNT_W   = 24;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/seven_seg_arb_rr_pick4.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_pick4
    import seven_seg_pkg::*;
(
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] ptr,
    output logic               valid,
    output logic [OWNER_W-1:0] idx
);
    logic [OWNER_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        valid  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = ptr + OWNER_W'(k);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end
endmodule

// File: rtl/seven_seg_arb.sv
// Four-way arbiter for the eight-digit seven-segment display: the winner
// owns val_o/dp_o for at least pHoldCnt cycles and may refresh while it owns.
module seven_seg_arb
    import seven_seg_pkg::*;
#(
    parameter int pClkFreq = 25000000,
    parameter int pHoldCnt = pClkFreq / 4
) (
    input  logic                rst,
    input  logic                clk,
    input  logic [NREQ-1:0]     req,
    input  logic [31:0]         val0,
    input  logic [31:0]         val1,
    input  logic [31:0]         val2,
    input  logic [31:0]         val3,
    input  logic [7:0]          dp0,
    input  logic [7:0]          dp1,
    input  logic [7:0]          dp2,
    input  logic [7:0]          dp3,
    output logic [NREQ-1:0]     ack,
    output logic [31:0]         val_o,
    output logic [7:0]          dp_o,
    output logic [OWNER_W-1:0]  owner,
    output logic                busy
);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(pHoldCnt - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [OWNER_W-1:0]  r_ptr;
    logic [OWNER_W-1:0]  r_owner;
    logic [NREQ-1:0]     r_ack;
    logic [31:0]         r_val;
    logic [7:0]          r_dp;
    logic                r_busy;

    logic [31:0]         w_val [NREQ];
    logic [7:0]          w_dp  [NREQ];
    logic [NREQ-1:0]     w_req_eff;
    logic                w_pick_vld;
    logic [OWNER_W-1:0]  w_pick_idx;

    assign w_val[0] = val0;
    assign w_val[1] = val1;
    assign w_val[2] = val2;
    assign w_val[3] = val3;
    assign w_dp[0]  = dp0;
    assign w_dp[1]  = dp1;
    assign w_dp[2]  = dp2;
    assign w_dp[3]  = dp3;

    // A request being acked this cycle is stale; masking it prevents a double latch.
    assign w_req_eff = req & ~r_ack;

    rr_pick4 u_pick (
        .req   (w_req_eff),
        .ptr   (r_ptr),
        .valid (w_pick_vld),
        .idx   (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
            r_ack   <= '0;
            r_val   <= '0;
            r_dp    <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_val             <= w_val[w_pick_idx];
                        r_dp              <= w_dp[w_pick_idx];
                        r_owner           <= w_pick_idx;
                        r_ack[w_pick_idx] <= 1'b1;
                        r_cnt             <= RELOAD;
                        r_ptr             <= w_pick_idx + OWNER_W'(1);
                        r_state           <= HOLD;
                        r_busy            <= 1'b1;
                    end
                end
                HOLD: begin
                    // The final cycle always releases; an owner request then waits for IDLE.
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_req_eff[r_owner]) begin
                        r_val          <= w_val[r_owner];
                        r_dp           <= w_dp[r_owner];
                        r_ack[r_owner] <= 1'b1;
                        r_cnt          <= RELOAD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack   = r_ack;
    assign val_o = r_val;
    assign dp_o  = r_dp;
    assign owner = r_owner;
    assign busy  = r_busy;
endmodule
